// File: rtl/btn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : btn_pkg                                                 |
// | Purpose  : Shared defaults and width helper for the push-button     |
// |            conditioner and selection-counter bank.                 |
// | Contents : DEB_W_DEF, CNT_W_DEF default widths;                     |
// |            clog2() sizes the hold and repeat counters.             |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package btn_pkg;

   localparam int DEB_W_DEF = 20;
   localparam int CNT_W_DEF = 2;

   // Number of bits needed to hold values 0 .. VALUE-1 (never less than 1).
   function automatic int clog2(input int unsigned value);
      int          w;
      int unsigned v;
      w = 0;
      v = 1;
      while (v < value) begin
         v = v << 1;
         w = w + 1;
      end
      if (w == 0) begin
         w = 1;
      end
      return w;
   endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_chan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : btn_chan                                                |
// | Purpose  : One button channel: 3-flop synchroniser, debounce,       |
// |            long-press detect, optional auto-repeat and a wrapping   |
// |            selection counter.                                      |
// | Ports    : ILA_clk, rstn (async, active-low)                        |
// |            btn_in    raw button pin                                 |
// |            cnt_max   wrap value for sel_cnt                         |
// |            clr       synchronous clear of sel_cnt                   |
// |            btn_level debounced level                                |
// |            btn_press 1-cycle press / auto-repeat pulse              |
// |            btn_long  1-cycle pulse when the press reaches HOLD_CYC  |
// |            sel_cnt   selection counter                              |
// |            sel_wrap  1-cycle pulse when sel_cnt wraps to 0          |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module btn_chan
   import btn_pkg::*;
#(
   parameter int DEB_W    = DEB_W_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int HOLD_CYC = 50000000,
   parameter int REP_CYC  = 10000000,
   parameter bit REP_ON   = 1'b0
) (
   input  logic             ILA_clk,
   input  logic             rstn,
   input  logic             btn_in,
   input  logic [CNT_W-1:0] cnt_max,
   input  logic             clr,
   output logic             btn_level,
   output logic             btn_press,
   output logic             btn_long,
   output logic [CNT_W-1:0] sel_cnt,
   output logic             sel_wrap
);

   localparam int HW = clog2(HOLD_CYC + 1);
   localparam int RW = clog2(REP_CYC);

   localparam logic [DEB_W-1:0] DEB_MAX  = '1;
   localparam logic [HW-1:0]    HOLD_MAX = HW'(HOLD_CYC);
   localparam logic [HW-1:0]    HOLD_PRE = HW'(HOLD_CYC - 1);
   localparam logic [RW-1:0]    REP_LAST = RW'(REP_CYC - 1);

   // sync_q[0] = s0, sync_q[1] = s1 (synchronised), sync_q[2] = s2 (previous s1)
   logic [2:0]       sync_q,    sync_d;
   logic [DEB_W-1:0] deb_q,     deb_d;
   logic             level_q,   level_d;
   logic             level_p_q, level_p_d;
   logic             press_q,   press_d;
   logic [HW-1:0]    hold_q,    hold_d;
   logic             long_q,    long_d;
   logic             rep_act_q, rep_act_d;
   logic [RW-1:0]    rep_q,     rep_d;
   logic [CNT_W-1:0] sel_q,     sel_d;
   logic             wrap_q,    wrap_d;

   logic             rep_fire;

   always_comb begin
      sync_d    = {sync_q[1:0], btn_in};
      deb_d     = deb_q;
      level_d   = level_q;
      level_p_d = level_q;
      hold_d    = '0;
      long_d    = 1'b0;
      rep_act_d = rep_act_q;
      rep_d     = rep_q;
      rep_fire  = 1'b0;
      press_d   = 1'b0;
      sel_d     = sel_q;
      wrap_d    = 1'b0;

      // Debounce window restarts on every change of the synchronised input.
      if (sync_q[1] != sync_q[2]) begin
         deb_d = '0;
      end else if (deb_q != DEB_MAX) begin
         deb_d = deb_q + 1'b1;
      end

      // The s1 == s2 term keeps a still-saturated counter from accepting the
      // very first sample of a new edge before the window has restarted.
      if ((deb_q == DEB_MAX) && (sync_q[1] == sync_q[2]) && (sync_q[1] != level_q)) begin
         level_d = sync_q[1];
      end

      if (level_q) begin
         hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
         long_d = (hold_q == HOLD_PRE);
      end

      rep_fire = REP_ON && level_q && rep_act_q && (rep_q == REP_LAST);

      if (!REP_ON || !level_q) begin
         rep_act_d = 1'b0;
         rep_d     = '0;
      end else if (long_d) begin
         rep_act_d = 1'b1;
         rep_d     = '0;
      end else if (rep_act_q) begin
         rep_d = rep_fire ? '0 : rep_q + 1'b1;
      end

      press_d = (level_q & ~level_p_q) | rep_fire;

      // >= rather than == so a cnt_max lowered under the count wraps next press.
      if (clr) begin
         sel_d = '0;
      end else if (press_q) begin
         if (sel_q >= cnt_max) begin
            sel_d  = '0;
            wrap_d = 1'b1;
         end else begin
            sel_d = sel_q + 1'b1;
         end
      end
   end

   always_ff @(posedge ILA_clk or negedge rstn) begin
      if (!rstn) begin
         sync_q    <= '0;
         deb_q     <= DEB_MAX;
         level_q   <= 1'b0;
         level_p_q <= 1'b0;
         press_q   <= 1'b0;
         hold_q    <= '0;
         long_q    <= 1'b0;
         rep_act_q <= 1'b0;
         rep_q     <= '0;
         sel_q     <= '0;
         wrap_q    <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         deb_q     <= deb_d;
         level_q   <= level_d;
         level_p_q <= level_p_d;
         press_q   <= press_d;
         hold_q    <= hold_d;
         long_q    <= long_d;
         rep_act_q <= rep_act_d;
         rep_q     <= rep_d;
         sel_q     <= sel_d;
         wrap_q    <= wrap_d;
      end
   end

   assign btn_level = level_q;
   assign btn_press = press_q;
   assign btn_long  = long_q;
   assign sel_cnt   = sel_q;
   assign sel_wrap  = wrap_q;

endmodule : btn_chan
`default_nettype wire

// File: rtl/btn_sel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : btn_sel_ctrl                                            |
// | Purpose  : Bank of NUM_BTN independent push-button conditioners     |
// |            with per-channel wrapping selection counters.            |
// | Ports    : ILA_clk, rstn (async, active-low)                        |
// |            btn_in    [NUM_BTN]       raw button pins                |
// |            cnt_max   [NUM_BTN*CNT_W] wrap values, ch i at i*CNT_W   |
// |            clr                       clear of all sel counters     |
// |            btn_level [NUM_BTN]       debounced levels               |
// |            btn_press [NUM_BTN]       press / repeat pulses          |
// |            btn_long  [NUM_BTN]       long-press pulses              |
// |            sel_cnt   [NUM_BTN*CNT_W] selection counters             |
// |            sel_wrap  [NUM_BTN]       counter wrap pulses            |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module btn_sel_ctrl
   import btn_pkg::*;
#(
   parameter int                 NUM_BTN  = 4,
   parameter int                 DEB_W    = DEB_W_DEF,
   parameter int                 CNT_W    = CNT_W_DEF,
   parameter int                 HOLD_CYC = 50000000,
   parameter int                 REP_CYC  = 10000000,
   parameter logic [NUM_BTN-1:0] REP_EN   = '0
) (
   input  logic                     ILA_clk,
   input  logic                     rstn,
   input  logic [NUM_BTN-1:0]       btn_in,
   input  logic [NUM_BTN*CNT_W-1:0] cnt_max,
   input  logic                     clr,
   output logic [NUM_BTN-1:0]       btn_level,
   output logic [NUM_BTN-1:0]       btn_press,
   output logic [NUM_BTN-1:0]       btn_long,
   output logic [NUM_BTN*CNT_W-1:0] sel_cnt,
   output logic [NUM_BTN-1:0]       sel_wrap
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_chan #(
         .DEB_W    (DEB_W),
         .CNT_W    (CNT_W),
         .HOLD_CYC (HOLD_CYC),
         .REP_CYC  (REP_CYC),
         .REP_ON   (REP_EN[i])
      ) u_chan (
         .ILA_clk   (ILA_clk),
         .rstn      (rstn),
         .btn_in    (btn_in[i]),
         .cnt_max   (cnt_max[i*CNT_W +: CNT_W]),
         .clr       (clr),
         .btn_level (btn_level[i]),
         .btn_press (btn_press[i]),
         .btn_long  (btn_long[i]),
         .sel_cnt   (sel_cnt[i*CNT_W +: CNT_W]),
         .sel_wrap  (sel_wrap[i])
      );
   end

endmodule : btn_sel_ctrl
`default_nettype wire
